phase_seq_ctrl: RTL and testbench

Controller that shares one 2-bit phase sequencer among up to N_REQ requesters. Round-robin arbitration grants exclusive ownership; the owner advances the phase by strobes and releases it with done. The block hardens its own state machine: any illegal state encoding recovers to IDLE and raises a sticky error. An optional watchdog forcibly reclaims a stalled owner.

---
 rtl/phase_seq_ctrl.sv | 132 +++++++++++++
 tb/tb_phase_seq_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/phase_seq_ctrl.sv
// rtl/phase_seq_ctrl.sv - round-robin owner of a shared 2-bit phase sequencer with hardened FSM
// Optional watchdog reclaim of a stalled owner: define PHASE_SEQ_WATCHDOG_EN.
module phase_seq_ctrl #(
  parameter int N_REQ    = 3,
  parameter int PHASE_W  = 2,
  parameter int HOLD_MAX = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   step,
  input  logic [N_REQ-1:0]   done,
  input  logic               err_clr,
  output logic [N_REQ-1:0]   gnt,
  output logic [PHASE_W-1:0] phase,
  output logic               busy,
  output logic               err_state,
  output logic               err_timeout
);

  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (N_REQ < 2 || N_REQ > 8 || HOLD_MAX < 2) begin : g_cfg_check
    $error("phase_seq_ctrl: unsupported parameter set");
  end

  typedef enum logic [3:0] {
    S_IDLE    = 4'b0001,
    S_GRANT   = 4'b0010,
    S_RUN     = 4'b0100,
    S_RELEASE = 4'b1000
  } state_e;

  // Plain vector so that any corrupted encoding is representable and caught by default.
  logic [3:0]    state;
  logic [OW-1:0] owner;
  logic [OW-1:0] rr_ptr;
  logic [OW-1:0] winner;
  logic          step_own;
  logic          done_own;
  logic          req_own;

  assign step_own = step[owner];
  assign done_own = done[owner];
  assign req_own  = req[owner];
  assign busy     = (state != S_IDLE);

  // Scan downward so the requester closest above rr_ptr is written last and wins.
  always_comb begin
    winner = rr_ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[(int'(rr_ptr) + i) % N_REQ]) begin
        winner = OW'((int'(rr_ptr) + i) % N_REQ);
      end
    end
  end

`ifdef PHASE_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(HOLD_MAX);
  logic [WD_W-1:0] wd_cnt;
`else
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      gnt       <= '0;
      phase     <= '0;
      err_state <= 1'b0;
      rr_ptr    <= '0;
      owner     <= '0;
`ifdef PHASE_SEQ_WATCHDOG_EN
      err_timeout <= 1'b0;
      wd_cnt      <= '0;
`endif
    end else begin
      // Clear first so a same-edge set further down takes priority.
      if (err_clr) begin
        err_state <= 1'b0;
`ifdef PHASE_SEQ_WATCHDOG_EN
        err_timeout <= 1'b0;
`endif
      end
      case (state)
        S_IDLE: begin
          if (|req) begin
            owner <= winner;
            state <= S_GRANT;
          end
        end
        S_GRANT: begin
          gnt   <= N_REQ'(1) << owner;
          phase <= '0;
          state <= S_RUN;
`ifdef PHASE_SEQ_WATCHDOG_EN
          wd_cnt <= '0;
`endif
        end
        S_RUN: begin
          if (step_own) phase <= phase + 1'b1;
          if (done_own || !req_own) begin
            state <= S_RELEASE;
          end
`ifdef PHASE_SEQ_WATCHDOG_EN
          else if (step_own) begin
            wd_cnt <= '0;
          end else if (wd_cnt == WD_W'(HOLD_MAX - 1)) begin
            state       <= S_RELEASE;
            err_timeout <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        S_RELEASE: begin
          gnt    <= '0;
          phase  <= '0;
          rr_ptr <= (owner == OW'(N_REQ - 1)) ? '0 : owner + 1'b1;
          state  <= S_IDLE;
        end
        default: begin
          state     <= S_IDLE;
          gnt       <= '0;
          phase     <= '0;
          err_state <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phase_seq_ctrl.sv
// tb/tb_phase_seq_ctrl.sv - randomized self-checking bench for phase_seq_ctrl
module tb_phase_seq_ctrl;

  localparam int N  = 3;
  localparam int PW = 2;
  localparam int HM = 16;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic [N-1:0]  req     = '0;
  logic [N-1:0]  step    = '0;
  logic [N-1:0]  done    = '0;
  logic          err_clr = 1'b0;
  logic [N-1:0]  gnt;
  logic [PW-1:0] phase;
  logic          busy;
  logic          err_state;
  logic          err_timeout;

  phase_seq_ctrl #(.N_REQ(N), .PHASE_W(PW), .HOLD_MAX(HM)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .step(step), .done(done), .err_clr(err_clr),
    .gnt(gnt), .phase(phase), .busy(busy), .err_state(err_state), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: 0 = nobody owns, 1 = winner chosen, 2 = owner holds, 3 = handing back.
  int           m_stage, m_owner, m_rr, m_phase, m_silent;
  logic [N-1:0] m_gnt;
  bit           m_err, m_to;

  task automatic m_reset();
    m_stage = 0; m_owner = 0; m_rr = 0; m_phase = 0; m_silent = 0;
    m_gnt = '0; m_err = 0; m_to = 0;
  endtask

  task automatic m_step();
    bit set_to = 0;
    case (m_stage)
      0: if (req != 0) begin
           for (int k = 0; k < N; k++) begin
             int c = (m_rr + k) % N;
             if (req[c]) begin m_owner = c; break; end
           end
           m_stage = 1;
         end
      1: begin m_gnt = N'(1) << m_owner; m_phase = 0; m_stage = 2; m_silent = 0; end
      2: begin
           if (step[m_owner]) m_phase = (m_phase + 1) % (1 << PW);
           if (done[m_owner] || !req[m_owner]) m_stage = 3;
           else if (step[m_owner]) m_silent = 0;
           else begin
             m_silent++;
`ifdef PHASE_SEQ_WATCHDOG_EN
             if (m_silent == HM) begin m_stage = 3; set_to = 1; end
`endif
           end
         end
      default: begin m_gnt = '0; m_phase = 0; m_rr = (m_owner + 1) % N; m_stage = 0; end
    endcase
    if (err_clr) m_err = 0;
    if (set_to) m_to = 1; else if (err_clr) m_to = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".gnt"}, 32'(gnt), 32'(m_gnt));
    check({tag, ".phase"}, 32'(phase), 32'(m_phase));
    check({tag, ".busy"}, 32'(busy), 32'(m_stage != 0));
    check({tag, ".err_state"}, 32'(err_state), 32'(m_err));
    check({tag, ".err_timeout"}, 32'(err_timeout), 32'(m_to));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    m_step();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic wait_run(input string tag);
    for (int c = 0; c < 12 && m_stage != 2; c++) tick(tag);
    check({tag, ".reach_run"}, 32'(|gnt), 32'd1);
  endtask

  int order[$];
  int exp_order[4] = '{0, 1, 2, 0};
  int exp_ph[5]    = '{1, 2, 3, 0, 1};
  logic [N-1:0] prev_g;

  initial begin
    m_reset();
    tick("reset");
    tick("reset");
    rst_n = 1'b1;

    for (int c = 0; c < 10; c++) begin
      tick("idle");
      check("idle_gnt", 32'(gnt), 32'd0);
    end

    // Round robin with every owner releasing after one RUN cycle.
    req = '1;
    prev_g = '0;
    for (int c = 0; c < 40 && order.size() < 4; c++) begin
      done = (m_stage == 2) ? (N'(1) << m_owner) : '0;
      tick("rr");
      if (gnt != 0 && prev_g == 0)
        for (int b = 0; b < N; b++) if (gnt[b]) order.push_back(b);
      prev_g = gnt;
    end
    done = '0;
    check("rr_count", 32'(order.size()), 32'd4);
    for (int i = 0; i < order.size() && i < 4; i++)
      check($sformatf("rr_order%0d", i), 32'(order[i]), 32'(exp_order[i]));
    req = '0;
    for (int c = 0; c < 4; c++) tick("drain");

    // Owner 1 stepping, with non-owner strobes in between.
    req = 3'b010;
    wait_run("own1");
    for (int i = 0; i < 5; i++) begin
      step = 3'b010;
      tick("step");
      check($sformatf("step_phase%0d", i), 32'(phase), 32'(exp_ph[i]));
      step = 3'b101;
      tick("foreign");
      check($sformatf("foreign_phase%0d", i), 32'(phase), 32'(exp_ph[i]));
    end
    step = 3'b010;
    tick("step2");
    check("phase_pre", 32'(phase), 32'd2);
    step = 3'b010; done = 3'b010;
    tick("step_done");
    check("sd_phase", 32'(phase), 32'd3);
    check("sd_gnt", 32'(gnt), 32'b010);
    step = '0; done = '0; req = '0;
    tick("release");
    check("rel_phase", 32'(phase), 32'd0);
    check("rel_gnt", 32'(gnt), 32'd0);
    for (int c = 0; c < 3; c++) tick("drain");

    // Corrupted state encoding.
    force dut.state = 4'b0110;
    @(posedge clk);
    @(negedge clk);
    check("ill_gnt", 32'(gnt), 32'd0);
    check("ill_phase", 32'(phase), 32'd0);
    check("ill_err", 32'(err_state), 32'd1);
    release dut.state;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    m_stage = 0; m_gnt = '0; m_phase = 0; m_err = 1;
    check_all("ill_recover");
    err_clr = 1'b1;
    tick("err_clr");
    err_clr = 1'b0;
    check("err_cleared", 32'(err_state), 32'd0);

    // Silent owner.
    req = 3'b001;
    wait_run("hold");
`ifdef PHASE_SEQ_WATCHDOG_EN
    for (int c = 0; c < HM - 1; c++) tick("wd");
    check("wd_pre", 32'(err_timeout), 32'd0);
    tick("wd");
    check("wd_fire", 32'(err_timeout), 32'd1);
    err_clr = 1'b1;
    tick("wd_clr");
    err_clr = 1'b0;
`else
    for (int c = 0; c < 100; c++) tick("hold");
    check("hold_gnt", 32'(gnt), 32'b001);
    check("hold_to", 32'(err_timeout), 32'd0);
`endif
    req = '0;
    for (int c = 0; c < 4; c++) tick("drain");

    // Asynchronous reset while an owner is running.
    req = 3'b001;
    wait_run("arst");
    step = 3'b001;
    tick("arst_step");
    step = '0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_gnt", 32'(gnt), 32'd0);
    check("arst_phase", 32'(phase), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    req = '0;
    tick("post_rst");

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) req = N'($urandom);
      step    = N'($urandom);
      done    = ($urandom_range(5) == 0) ? N'($urandom) : '0;
      err_clr = ($urandom_range(15) == 0);
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
